// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and the IF/ID pipeline payload.
package cpu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned IMEM_DEPTH = 32;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam logic [31:0] PC_INCR    = 32'd4;

    // Contents of the IF/ID pipeline register
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write port, asynchronous read port.
module instr_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [31:0]     wdata,
    input  logic [AW-1:0]   raddr,
    output logic [31:0]     rdata
);

    logic [31:0] mem [DEPTH];

    // Write one word per enabled cycle; contents are never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: loadable instruction memory, program counter and IF/ID register.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = IMEM_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            LoadInstructions,
    input  logic [31:0]     Instruction,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic [31:0]     BranchTarget,
    output logic [31:0]     PC,
    output logic [31:0]     IF_ID_Instr,
    output logic [31:0]     IF_ID_PC4,
    output logic            IF_ID_Valid,
    output logic            ProgramDone,
    output logic [AW:0]     LoadCount,
    output logic            LoadOverflow
);

    logic          load_d;
    logic [AW:0]   wptr;
    // Survive Reset so a loaded program outlives the reset before a run
    logic [AW:0]   load_count    = '0;
    logic          load_overflow = 1'b0;
    logic [31:0]   pc;
    if_id_t        if_id;

    logic          new_session;
    logic          mem_full;
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] fetch_idx;
    logic          fetch_ok;
    logic [31:0]   mem_rdata;

    assign new_session = LoadInstructions && !load_d;
    assign mem_full    = (wptr == (AW+1)'(DEPTH));
    assign we          = !Reset && LoadInstructions && (new_session || !mem_full);
    assign waddr       = new_session ? '0 : wptr[AW-1:0];

    // Only words of the last load session inside the array are fetchable
    assign fetch_idx = pc[AW+1:2];
    assign fetch_ok  = (pc[31:AW+2] == '0) && ((AW+1)'(fetch_idx) < load_count);

    instr_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (Instruction),
        .raddr (fetch_idx),
        .rdata (mem_rdata)
    );

    // Load session tracking: write pointer, word count and sticky overflow
    always_ff @(posedge clk) begin
        if (Reset) begin
            load_d <= 1'b0;
            wptr   <= '0;
        end else begin
            load_d <= LoadInstructions;
            if (LoadInstructions) begin
                if (new_session) begin
                    wptr          <= (AW+1)'(1);
                    load_count    <= (AW+1)'(1);
                    load_overflow <= 1'b0;
                end else if (mem_full) begin
                    load_overflow <= 1'b1;
                end else begin
                    wptr       <= wptr + (AW+1)'(1);
                    load_count <= load_count + (AW+1)'(1);
                end
            end
        end
    end

    // Program counter and IF/ID register: load > branch > stall > fetch
    always_ff @(posedge clk) begin
        if (Reset) begin
            pc    <= '0;
            if_id <= '0;
        end else if (LoadInstructions) begin
            pc          <= '0;
            if_id.instr <= INSTR_NOP;
            if_id.pc4   <= '0;
            if_id.valid <= 1'b0;
        end else if (BranchTaken) begin
            pc          <= BranchTarget & ~32'h0000_0003;
            if_id.instr <= INSTR_NOP;
            if_id.pc4   <= '0;
            if_id.valid <= 1'b0;
        end else if (!Stall) begin
            pc          <= pc + PC_INCR;
            if_id.instr <= fetch_ok ? mem_rdata : INSTR_NOP;
            if_id.pc4   <= pc + PC_INCR;
            if_id.valid <= 1'b1;
        end
    end

    assign PC           = pc;
    assign IF_ID_Instr  = if_id.instr;
    assign IF_ID_PC4    = if_id.pc4;
    assign IF_ID_Valid  = if_id.valid;
    assign LoadCount    = load_count;
    assign LoadOverflow = load_overflow;
    assign ProgramDone  = (pc[31:2] >= 30'(load_count));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (DEPTH 32 with a reference model, plus a DEPTH 4 copy).
module tb_instr_fetch_unit;

    localparam int MD = 32;

    logic        clk;
    logic        Reset, LoadInstructions, Stall, BranchTaken;
    logic [31:0] Instruction, BranchTarget;
    logic [31:0] PC, IF_ID_Instr, IF_ID_PC4;
    logic        IF_ID_Valid, ProgramDone, LoadOverflow;
    logic [5:0]  LoadCount;

    logic        s_reset, s_load, s_stall, s_branch;
    logic [31:0] s_instr, s_target;
    logic [31:0] s_pc, s_if_instr, s_if_pc4;
    logic        s_valid, s_done, s_ovf;
    logic [2:0]  s_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_mem [MD];
    int          m_wptr, m_cnt;
    logic        m_ovf, m_loadd, m_valid;
    logic [31:0] m_pc, m_instr, m_pc4;

    logic [31:0] prog [11];
    logic [31:0] sw   [6];

    instr_fetch_unit #(.DEPTH(32)) u_dut (
        .clk(clk), .Reset(Reset), .LoadInstructions(LoadInstructions),
        .Instruction(Instruction), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .PC(PC), .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid), .ProgramDone(ProgramDone),
        .LoadCount(LoadCount), .LoadOverflow(LoadOverflow)
    );

    instr_fetch_unit #(.DEPTH(4)) u_small (
        .clk(clk), .Reset(s_reset), .LoadInstructions(s_load),
        .Instruction(s_instr), .Stall(s_stall), .BranchTaken(s_branch),
        .BranchTarget(s_target), .PC(s_pc), .IF_ID_Instr(s_if_instr),
        .IF_ID_PC4(s_if_pc4), .IF_ID_Valid(s_valid), .ProgramDone(s_done),
        .LoadCount(s_count), .LoadOverflow(s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the specified per-cycle rules to the model at a clock edge
    task automatic model_step();
        int idx;
        if (Reset) begin
            m_pc = 0; m_wptr = 0; m_loadd = 0;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else begin
            if (LoadInstructions) begin
                if (!m_loadd) begin m_wptr = 0; m_cnt = 0; m_ovf = 0; end
                if (m_wptr < MD) begin
                    m_mem[m_wptr] = Instruction;
                    m_wptr++;
                    m_cnt = m_wptr;
                end else begin
                    m_ovf = 1;
                end
                m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (BranchTaken) begin
                m_pc = BranchTarget & ~32'd3;
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (!Stall) begin
                idx = int'(m_pc / 4);
                m_instr = (m_pc / 4 < 32'(m_cnt)) ? m_mem[idx] : 32'h0;
                m_pc4 = m_pc + 4;
                m_pc = m_pc + 4;
                m_valid = 1;
            end
            m_loadd = LoadInstructions;
        end
    endtask

    task automatic check_model();
        chk("m_pc", PC, m_pc);
        chk("m_instr", IF_ID_Instr, m_instr);
        chk("m_pc4", IF_ID_PC4, m_pc4);
        chk("m_valid", 32'(IF_ID_Valid), 32'(m_valid));
        chk("m_count", 32'(LoadCount), 32'(m_cnt));
        chk("m_ovf", 32'(LoadOverflow), 32'(m_ovf));
        chk("m_done", 32'(ProgramDone), 32'((m_pc / 4) >= 32'(m_cnt)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        Reset = 1; LoadInstructions = 0; Instruction = 0; Stall = 0;
        BranchTaken = 0; BranchTarget = 0;
        s_reset = 1; s_load = 0; s_instr = 0; s_stall = 0; s_branch = 0; s_target = 0;
        m_cnt = 0; m_ovf = 0; m_wptr = 0; m_loadd = 0;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        for (int i = 0; i < MD; i++) m_mem[i] = 0;
        for (int i = 0; i < 11; i++) prog[i] = 32'h1000_0000 + 32'(i * 17);
        prog[0] = 32'h2001_01A7;
        prog[2] = 32'h2003_000D;

        // Reset state, power-on count/overflow
        tick(); tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", 32'(IF_ID_Valid), 32'h0);
        chk("rst_instr", IF_ID_Instr, 32'h0);
        chk("rst_count", 32'(LoadCount), 32'h0);
        chk("rst_ovf", 32'(LoadOverflow), 32'h0);

        // Load 11 words, reset, then run
        Reset = 0; LoadInstructions = 1;
        for (int i = 0; i < 11; i++) begin Instruction = prog[i]; tick(); end
        LoadInstructions = 0; Reset = 1; tick();
        chk("load_count11", 32'(LoadCount), 32'd11);
        Reset = 0; tick();
        chk("first_instr", IF_ID_Instr, 32'h2001_01A7);
        chk("first_pc4", IF_ID_PC4, 32'h4);
        chk("first_pc", PC, 32'h4);
        tick();
        chk("second_instr", IF_ID_Instr, prog[1]);

        // Stall for 3 cycles at PC 8
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", PC, 32'h8);
            chk("stall_instr", IF_ID_Instr, prog[1]);
        end
        Stall = 0; tick();
        chk("after_stall", IF_ID_Instr, 32'h2003_000D);

        // Branch wins over a simultaneous stall
        BranchTaken = 1; BranchTarget = 32'h0000_000B; Stall = 1; tick();
        chk("br_pc", PC, 32'h8);
        chk("br_valid", 32'(IF_ID_Valid), 32'h0);
        BranchTaken = 0; Stall = 0; tick();
        chk("br_target_instr", IF_ID_Instr, 32'h2003_000D);
        chk("br_target_valid", 32'(IF_ID_Valid), 32'h1);

        // Run to the end of the program
        for (int i = 0; i < 7; i++) tick();
        chk("pre_end_pc", PC, 32'h28);
        chk("pre_end_done", 32'(ProgramDone), 32'h0);
        tick();
        chk("end_pc", PC, 32'h2C);
        chk("end_done", 32'(ProgramDone), 32'h1);
        chk("last_word", IF_ID_Instr, prog[10]);
        tick();
        chk("past_end_instr", IF_ID_Instr, 32'h0);
        chk("past_end_valid", 32'(IF_ID_Valid), 32'h1);
        chk("past_end_pc4", IF_ID_PC4, 32'h30);

        // Randomized mix of load bursts, resets, branches and stalls
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                int n;
                n = int'($urandom_range(1, 40));
                LoadInstructions = 1; Reset = 0; Stall = 0; BranchTaken = 0;
                for (int k = 0; k < n; k++) begin
                    Instruction = $urandom;
                    Stall = $urandom_range(0, 1) == 1;
                    BranchTaken = $urandom_range(0, 1) == 1;
                    tick();
                end
                LoadInstructions = 0;
                Reset = $urandom_range(0, 1) == 1;
                tick();
                Reset = 0;
            end else begin
                Reset = (r < 6);
                Stall = $urandom_range(0, 4) == 0;
                BranchTaken = $urandom_range(0, 9) == 0;
                BranchTarget = ($urandom_range(0, 7) == 0) ? $urandom
                                                           : 32'($urandom_range(0, 160));
                tick();
            end
        end
        Reset = 0; Stall = 0; BranchTaken = 0;

        // Reset in the middle of a load session
        LoadInstructions = 1;
        Instruction = 32'hAAAA_0000; tick();
        Instruction = 32'hBBBB_1111; tick();
        Instruction = 32'hCCCC_2222; tick();
        Reset = 1; Instruction = 32'hDEAD_BEEF; tick();
        Reset = 0;
        Instruction = 32'h1111_AAAA; tick();
        Instruction = 32'h2222_BBBB; tick();
        LoadInstructions = 0; Reset = 1; tick();
        chk("abort_count", 32'(LoadCount), 32'd2);
        chk("abort_mem2", u_dut.u_imem.mem[2], 32'hCCCC_2222);
        Reset = 0; tick();
        chk("abort_w0", IF_ID_Instr, 32'h1111_AAAA);
        tick();
        chk("abort_w1", IF_ID_Instr, 32'h2222_BBBB);
        tick();
        chk("abort_w2_nop", IF_ID_Instr, 32'h0);
        chk("abort_w2_valid", 32'(IF_ID_Valid), 32'h1);

        // DEPTH 4 copy: overflow on the fifth word
        for (int i = 0; i < 6; i++) sw[i] = 32'h5000_0000 + 32'(i);
        s_reset = 0; s_load = 1;
        for (int i = 0; i < 6; i++) begin
            s_instr = sw[i];
            tick();
            if (i == 3) chk("s_ovf_at4", 32'(s_ovf), 32'h0);
            if (i == 4) chk("s_ovf_at5", 32'(s_ovf), 32'h1);
        end
        chk("s_count", 32'(s_count), 32'd4);
        chk("s_ovf", 32'(s_ovf), 32'h1);
        s_load = 0; s_reset = 1; tick();
        s_reset = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s_word", s_if_instr, sw[i]);
        end
        chk("s_done", 32'(s_done), 32'h1);
        tick();
        chk("s_wrap_nop", s_if_instr, 32'h0);
        chk("s_wrap_valid", 32'(s_valid), 32'h1);
        s_load = 1; s_instr = 32'h7777_7777; tick();
        s_load = 0;
        chk("s_new_ovf", 32'(s_ovf), 32'h0);
        chk("s_new_count", 32'(s_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
